// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry, state encoding and address helpers for the
// direct-mapped data-cache controller (64 sets, 16-byte lines, 2 beats).
package dcache_pkg;
  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int MW    = DW / 8;
  localparam int TAGW  = AW - 10;
  localparam int IDXW  = 6;
  localparam int OFFW  = 4;
  localparam int BEATS = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_REQ,
    WB_DATA,
    RF_REQ,
    RF_DATA,
    REPLAY
  } state_e;

  function automatic logic [AW-1:0] line_addr(
    input logic [TAGW-1:0] tag,
    input logic [IDXW-1:0] idx
  );
    return {tag, idx, {OFFW{1'b0}}};
  endfunction
endpackage

// File: rtl/dcache_if.sv
// dcache_if: LSU request/response handshake between the load-store unit
// (master) and the data-cache controller (slave).
interface dcache_if;
  import dcache_pkg::*;

  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_we;
  logic [DW-1:0] req_wdata;
  logic [MW-1:0] req_wmask;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_wmask,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_wmask,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/dcache_addr_split.sv
// dcache_addr_split: tag/index/beat extraction and line-address build.
// The byte offset never reaches this block.
module dcache_addr_split
  import dcache_pkg::*;
(
  input  logic [AW-1:3]   addr,
  output logic [TAGW-1:0] tag,
  output logic [IDXW-1:0] idx,
  output logic            beat,
  output logic [AW-1:0]   line
);
  assign tag  = addr[AW-1:AW-TAGW];
  assign idx  = addr[OFFW+IDXW-1:OFFW];
  assign beat = addr[3];
  assign line = line_addr(tag, idx);
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped D$ controller (lookup, write-hit, writeback,
// refill). Define DCACHE_PERF_CNT_EN to add saturating hit/miss counters.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  dcache_if.slave         lsu,
  output logic [IDXW-1:0] ta_addr,
  output logic            ta_cen_n,
  output logic            ta_wen_n,
  output logic [TAGW-1:0] ta_wdata,
  input  logic [TAGW-1:0] ta_rdata,
  output logic [IDXW:0]   da_addr,
  output logic            da_cen_n,
  output logic            da_wen_n,
  output logic [MW-1:0]   da_wmask,
  output logic [DW-1:0]   da_wdata,
  input  logic [DW-1:0]   da_rdata,
  output logic [IDXW-1:0] vd_addr,
  output logic            v_en_n,
  output logic            v_we_n,
  output logic            v_in,
  input  logic            v_o,
  output logic            d_en_n,
  output logic            d_we_n,
  output logic            d_in,
  input  logic            d_o,
  output logic            mem_req,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wvalid,
  input  logic            mem_wready,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_rvalid,
  input  logic            mem_rlast,
  input  logic [DW-1:0]   mem_rdata
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]     perf_hit,
  output logic [31:0]     perf_miss
`endif
);
  state_e          state_q, state_d;
  logic            beat_q, beat_d;
  logic [AW-1:3]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]   wmask_q, wmask_d;
  logic [TAGW-1:0] victim_q, victim_d;
  logic [DW-1:0]   wbuf_q, wbuf_d;
  logic            rd_pend_q, rd_pend_d;

  logic [AW-1:3]   cur_addr;
  logic [TAGW-1:0] tag;
  logic [IDXW-1:0] idx;
  logic            rbeat;
  logic [AW-1:0]   line;
  logic            hit;
  logic            lk_rd;
  logic            unused_boff;

  assign unused_boff = ^lsu.req_addr[2:0];
  assign cur_addr = (state_q == IDLE) ? lsu.req_addr[AW-1:3] : addr_q;
  assign hit = v_o && (ta_rdata == tag);

  dcache_addr_split u_split (
    .addr (cur_addr),
    .tag  (tag),
    .idx  (idx),
    .beat (rbeat),
    .line (line)
  );

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    victim_d  = victim_q;
    wbuf_d    = wbuf_q;
    rd_pend_d = 1'b0;
    lk_rd     = 1'b0;

    lsu.req_ready  = 1'b0;
    lsu.resp_valid = 1'b0;
    lsu.resp_rdata = '0;
    ta_addr    = '0;
    ta_cen_n   = 1'b1;
    ta_wen_n   = 1'b1;
    ta_wdata   = '0;
    da_addr    = '0;
    da_cen_n   = 1'b1;
    da_wen_n   = 1'b1;
    da_wmask   = '0;
    da_wdata   = '0;
    vd_addr    = '0;
    v_en_n     = 1'b1;
    v_we_n     = 1'b1;
    v_in       = 1'b0;
    d_en_n     = 1'b1;
    d_we_n     = 1'b1;
    d_in       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wvalid = 1'b0;
    mem_wdata  = '0;

    // Capture the beat one cycle after its read; hold it while stalled.
    if (rd_pend_q) wbuf_d = da_rdata;

    unique case (state_q)
      IDLE: begin
        lsu.req_ready = 1'b1;
        if (lsu.req_valid) begin
          lk_rd   = 1'b1;
          addr_d  = lsu.req_addr[AW-1:3];
          we_d    = lsu.req_we;
          wdata_d = lsu.req_wdata;
          wmask_d = lsu.req_wmask;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          lsu.resp_valid = 1'b1;
          if (we_q) begin
            da_addr  = {idx, rbeat};
            da_cen_n = 1'b0;
            da_wen_n = 1'b0;
            da_wmask = wmask_q;
            da_wdata = wdata_q;
            vd_addr  = idx;
            d_en_n   = 1'b0;
            d_we_n   = 1'b0;
            d_in     = 1'b1;
          end else begin
            lsu.resp_rdata = da_rdata;
          end
          state_d = IDLE;
        end else if (v_o && d_o) begin
          victim_d = ta_rdata;
          state_d  = WB_REQ;
        end else begin
          state_d = RF_REQ;
        end
      end
      WB_REQ: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = line_addr(victim_q, idx);
        da_addr   = {idx, 1'b0};
        da_cen_n  = 1'b0;
        rd_pend_d = 1'b1;
        if (mem_ready) begin
          beat_d  = 1'b0;
          state_d = WB_DATA;
        end
      end
      WB_DATA: begin
        mem_wvalid = 1'b1;
        mem_wdata  = rd_pend_q ? da_rdata : wbuf_q;
        if (mem_wready) begin
          if (beat_q) begin
            beat_d  = 1'b0;
            state_d = RF_REQ;
          end else begin
            da_addr   = {idx, 1'b1};
            da_cen_n  = 1'b0;
            rd_pend_d = 1'b1;
            beat_d    = 1'b1;
          end
        end
      end
      RF_REQ: begin
        mem_req  = 1'b1;
        mem_addr = line;
        if (mem_ready) begin
          beat_d  = 1'b0;
          state_d = RF_DATA;
        end
      end
      RF_DATA: begin
        if (mem_rvalid) begin
          da_addr  = {idx, beat_q};
          da_cen_n = 1'b0;
          da_wen_n = 1'b0;
          da_wmask = '1;
          da_wdata = mem_rdata;
          beat_d   = beat_q + 1'b1;
          if (mem_rlast) begin
            ta_addr  = idx;
            ta_cen_n = 1'b0;
            ta_wen_n = 1'b0;
            ta_wdata = tag;
            vd_addr  = idx;
            v_en_n   = 1'b0;
            v_we_n   = 1'b0;
            v_in     = 1'b1;
            d_en_n   = 1'b0;
            d_we_n   = 1'b0;
            d_in     = 1'b0;
            beat_d   = 1'b0;
            state_d  = REPLAY;
          end
        end
      end
      REPLAY: begin
        lk_rd   = 1'b1;
        state_d = LOOKUP;
      end
      default: state_d = IDLE;
    endcase

    if (lk_rd) begin
      ta_addr  = idx;
      ta_cen_n = 1'b0;
      vd_addr  = idx;
      v_en_n   = 1'b0;
      d_en_n   = 1'b0;
      da_addr  = {idx, rbeat};
      da_cen_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      beat_q    <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      victim_q  <= '0;
      wbuf_q    <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      victim_q  <= victim_d;
      wbuf_q    <= wbuf_d;
      rd_pend_q <= rd_pend_d;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic        replay_q, replay_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // A lookup straight after REPLAY is the refill's own hit, not a new one.
  always_comb begin
    replay_d   = (state_q == REPLAY);
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == LOOKUP && hit && !replay_q && hit_cnt_q != '1)
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (state_q == LOOKUP && !hit && miss_cnt_q != '1)
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      replay_q   <= replay_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign perf_hit  = hit_cnt_q;
  assign perf_miss = miss_cnt_q;
`endif
endmodule
